// File: rtl/slink_bist_prbs_chk.sv
// Multi-channel self-synchronising BIST checker for counter and PRBS7/15/23/31 app streams.
// Each channel owns a lock FSM, a prediction history and a saturating per-word error counter.
module slink_bist_prbs_chk #(
   parameter int  DATA_WIDTH = 32,
   parameter int  NUM_CH     = 4,
   parameter int  ERR_W      = 16,
   parameter int  LOCK_CNT   = 8,
   parameter int  UNREC_CNT  = 4,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic                    clear,
   input  logic [2:0]              mode,
   input  logic                    valid,
   input  logic [CH_W-1:0]         ch,
   input  logic [DATA_WIDTH-1:0]   data,
   output logic [NUM_CH-1:0]       locked,
   output logic [NUM_CH-1:0]       unrec,
   output logic [NUM_CH*ERR_W-1:0] err_count,
   output logic                    err_pulse
);

   localparam int MC_W = $clog2(LOCK_CNT + 1);
   localparam int UC_W = $clog2(UNREC_CNT + 1);
   localparam logic [MC_W-1:0] LOCK_LAST  = MC_W'(LOCK_CNT - 1);
   localparam logic [UC_W-1:0] UNREC_LAST = UC_W'(UNREC_CNT - 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_LOCKED = 2'd1,
      ST_UNREC  = 2'd2
   } state_t;

   // Tap positions of b_(k-N) and b_(k-M) inside a word-wide history whose MSB is the newest bit.
   function automatic logic [DATA_WIDTH-1:0] tap_mask(input logic [2:0] m);
      logic [DATA_WIDTH-1:0] one;
      one = DATA_WIDTH'(1);
      case (m)
         3'd1:    tap_mask = (one << (DATA_WIDTH - 7))  | (one << (DATA_WIDTH - 6));
         3'd2:    tap_mask = (one << (DATA_WIDTH - 15)) | (one << (DATA_WIDTH - 14));
         3'd3:    tap_mask = (one << (DATA_WIDTH - 23)) | (one << (DATA_WIDTH - 18));
         3'd4:    tap_mask = (one << (DATA_WIDTH - 31)) | (one << (DATA_WIDTH - 28));
         default: tap_mask = '0;
      endcase
   endfunction

   // Next expected word; modes without taps (0 and the aliases 5-7) fall back to the counter.
   function automatic logic [DATA_WIDTH-1:0] predict(input logic [DATA_WIDTH-1:0] prev,
                                                     input logic [2:0]            m);
      logic [DATA_WIDTH-1:0] mask;
      logic [DATA_WIDTH-1:0] sr;
      mask = tap_mask(m);
      sr   = prev;
      if (mask == '0) begin
         sr = prev + DATA_WIDTH'(1);
      end else begin
         for (int k = 0; k < DATA_WIDTH; k++) begin
            sr = {^(sr & mask), sr[DATA_WIDTH-1:1]};
         end
      end
      return sr;
   endfunction

   logic [2:0]            mode_q;
   state_t                state_q    [NUM_CH];
   state_t                state_d    [NUM_CH];
   logic [DATA_WIDTH-1:0] hist_q     [NUM_CH];
   logic [DATA_WIDTH-1:0] hist_d     [NUM_CH];
   logic                  hist_vld_q [NUM_CH];
   logic                  hist_vld_d [NUM_CH];
   logic [MC_W-1:0]       match_q    [NUM_CH];
   logic [MC_W-1:0]       match_d    [NUM_CH];
   logic [UC_W-1:0]       consec_q   [NUM_CH];
   logic [UC_W-1:0]       consec_d   [NUM_CH];
   logic [ERR_W-1:0]      err_q      [NUM_CH];
   logic [ERR_W-1:0]      err_d      [NUM_CH];
   logic                  err_pulse_d;

   logic                  flush;
   logic                  hit;
   logic [DATA_WIDTH-1:0] hist_sel;
   logic [DATA_WIDTH-1:0] expect_w;
   logic                  data_ok;

   // A single predictor is shared: only the addressed channel can update in a cycle.
   always_comb begin
      flush    = clear || (en && (mode != mode_q));
      hit      = en && valid && !flush;
      hist_sel = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch == CH_W'(k)) hist_sel = hist_q[k];
      end
      expect_w = predict(hist_sel, mode_q);
      data_ok  = (data == expect_w);
   end

   // NOTE: every next-state variable takes its hold value first so no path can infer a latch.
   always_comb begin
      err_pulse_d = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         state_d[k]    = state_q[k];
         hist_d[k]     = hist_q[k];
         hist_vld_d[k] = hist_vld_q[k];
         match_d[k]    = match_q[k];
         consec_d[k]   = consec_q[k];
         err_d[k]      = err_q[k];

         if (flush) begin
            state_d[k]    = ST_SEARCH;
            hist_vld_d[k] = 1'b0;
            match_d[k]    = '0;
            consec_d[k]   = '0;
            err_d[k]      = '0;
         end else if (hit && (ch == CH_W'(k))) begin
            case (state_q[k])
               ST_SEARCH: begin
                  hist_d[k]     = data;
                  hist_vld_d[k] = 1'b1;
                  if (hist_vld_q[k] && data_ok) begin
                     if (match_q[k] == LOCK_LAST) begin
                        state_d[k]  = ST_LOCKED;
                        match_d[k]  = '0;
                        consec_d[k] = '0;
                     end else begin
                        match_d[k] = match_q[k] + 1'b1;
                     end
                  end else begin
                     match_d[k] = '0;
                  end
               end
               ST_LOCKED: begin
                  // Free-running on its own prediction so a corrupted word never reseeds it.
                  hist_d[k] = expect_w;
                  if (!data_ok) begin
                     err_pulse_d = 1'b1;
                     if (err_q[k] != '1) err_d[k] = err_q[k] + 1'b1;
                     if (consec_q[k] == UNREC_LAST) begin
                        state_d[k] = ST_UNREC;
                     end else begin
                        consec_d[k] = consec_q[k] + 1'b1;
                     end
                  end else begin
                     consec_d[k] = '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: non-blocking assignments keep every register update in this block order-independent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q    <= '0;
         err_pulse <= 1'b0;
         // NOTE: the per-channel arrays are flops, not RAM, so each entry is reset explicitly.
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k]    <= ST_SEARCH;
            hist_q[k]     <= '0;
            hist_vld_q[k] <= 1'b0;
            match_q[k]    <= '0;
            consec_q[k]   <= '0;
            err_q[k]      <= '0;
         end
      end else begin
         if (en) mode_q <= mode;
         err_pulse <= err_pulse_d;
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k]    <= state_d[k];
            hist_q[k]     <= hist_d[k];
            hist_vld_q[k] <= hist_vld_d[k];
            match_q[k]    <= match_d[k];
            consec_q[k]   <= consec_d[k];
            err_q[k]      <= err_d[k];
         end
      end
   end

   always_comb begin
      locked    = '0;
      unrec     = '0;
      err_count = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         locked[k]                    = (state_q[k] == ST_LOCKED);
         unrec[k]                     = (state_q[k] == ST_UNREC);
         err_count[k*ERR_W +: ERR_W]  = err_q[k];
      end
   end

endmodule

// File: tb/tb_slink_bist_prbs_chk.sv
// Directed bench for slink_bist_prbs_chk: lock, error counting, saturation, unrec, clear, en and channel drop.
// Three instances share the stimulus: default, a 4-bit error counter one, and a 3-channel one.
module tb_slink_bist_prbs_chk;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic        clear;
   logic [2:0]  mode;
   logic        valid;
   logic [1:0]  ch;
   logic [31:0] data;

   logic [3:0]  locked,   unrec;
   logic [63:0] err_count;
   logic        err_pulse;
   logic [3:0]  locked_e, unrec_e;
   logic [15:0] err_count_e;
   logic        err_pulse_e;
   logic [2:0]  locked_n, unrec_n;
   logic [47:0] err_count_n;
   logic        err_pulse_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   slink_bist_prbs_chk dut (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .mode(mode), .valid(valid),
      .ch(ch), .data(data), .locked(locked), .unrec(unrec), .err_count(err_count),
      .err_pulse(err_pulse)
   );

   slink_bist_prbs_chk #(.ERR_W(4)) dut_e (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .mode(mode), .valid(valid),
      .ch(ch), .data(data), .locked(locked_e), .unrec(unrec_e), .err_count(err_count_e),
      .err_pulse(err_pulse_e)
   );

   slink_bist_prbs_chk #(.NUM_CH(3)) dut_n (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .mode(mode), .valid(valid),
      .ch(ch), .data(data), .locked(locked_n), .unrec(unrec_n), .err_count(err_count_n),
      .err_pulse(err_pulse_n)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Serial reference generator: bit i steps ago lives at gh[c][i-1].
   logic [63:0] gh    [4];
   logic [31:0] cnt_w [4];
   int          pn = 0;
   int          pm = 0;

   task automatic next_word(input int c, output logic [31:0] w);
      logic b;
      w = '0;
      if (pn == 0) begin
         w        = cnt_w[c];
         cnt_w[c] = cnt_w[c] + 32'd1;
      end else begin
         for (int k = 0; k < 32; k++) begin
            b     = gh[c][pn-1] ^ gh[c][pm-1];
            gh[c] = {gh[c][62:0], b};
            w[k]  = b;
         end
      end
   endtask

   task automatic send(input logic [1:0] c, input logic [31:0] d);
      ch    = c;
      data  = d;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic send_good(input int c, input int n);
      logic [31:0] w;
      repeat (n) begin
         next_word(c, w);
         send(2'(c), w);
      end
   endtask

   task automatic send_bad(input int c, input logic [31:0] flip);
      logic [31:0] w;
      next_word(c, w);
      send(2'(c), w ^ flip);
   endtask

   task automatic set_mode(input logic [2:0] m, input int n, input int t);
      mode  = m;
      pn    = n;
      pm    = t;
      en    = 1'b1;
      valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      gh[0] = 64'h0123_4567_89AB_CDEF;
      gh[1] = 64'h0F1E_2D3C_4B5A_6978;
      gh[2] = 64'hACE1_2345_6789_BEEF;
      gh[3] = 64'h5A5A_A5A5_1357_9BDF;
      for (int i = 0; i < 4; i++) cnt_w[i] = '0;
      reset_n = 1'b0;
      en      = 1'b0;
      clear   = 1'b0;
      mode    = 3'd0;
      valid   = 1'b0;
      ch      = '0;
      data    = '0;
      repeat (2) @(negedge clk);

      check("rst_locked",    64'(locked),    64'h0);
      check("rst_unrec",     64'(unrec),     64'h0);
      check("rst_err_count", err_count,      64'h0);
      check("rst_err_pulse", 64'(err_pulse), 64'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // PRBS7 on ch0: the first word only seeds, lock follows the ninth.
      set_mode(3'd1, 7, 6);
      send_good(0, 8);
      check("prbs7_8_words_unlocked", 64'(locked[0]), 64'h0);
      send_good(0, 1);
      check("prbs7_9_words_locked", 64'(locked[0]), 64'h1);
      check("prbs7_no_errors", 64'(err_count[15:0]), 64'h0);

      // Asynchronous reset mid-stream, then relock from scratch.
      reset_n = 1'b0;
      #1;
      check("reset_async_locked", 64'(locked), 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      set_mode(3'd1, 7, 6);
      send_good(0, 8);
      check("relock_8_words_unlocked", 64'(locked[0]), 64'h0);
      send_good(0, 1);
      check("relock_9_words_locked", 64'(locked[0]), 64'h1);

      // PRBS31 on ch2 with a single flipped bit.
      set_mode(3'd4, 31, 28);
      check("mode_change_unlocks", 64'(locked), 64'h0);
      send_good(2, 9);
      check("prbs31_locked", 64'(locked[2]), 64'h1);
      send_bad(2, 32'h0000_0020);
      check("bit5_err_pulse",  64'(err_pulse),         64'h1);
      check("bit5_err_count",  64'(err_count[47:32]),  64'h1);
      check("bit5_still_lock", 64'(locked[2]),         64'h1);
      send_good(2, 1);
      check("clean_after_err_pulse", 64'(err_pulse),        64'h0);
      check("clean_after_err_count", 64'(err_count[47:32]), 64'h1);

      // Four consecutive errors on ch1 make it unrecoverable.
      send_good(1, 9);
      check("ch1_locked", 64'(locked[1]), 64'h1);
      repeat (3) send_bad(1, 32'h0000_0001);
      check("ch1_3err_unrec",  64'(unrec[1]),          64'h0);
      check("ch1_3err_locked", 64'(locked[1]),         64'h1);
      send_bad(1, 32'h0000_0001);
      check("ch1_4err_unrec",  64'(unrec[1]),          64'h1);
      check("ch1_4err_locked", 64'(locked[1]),         64'h0);
      check("ch1_4err_count",  64'(err_count[31:16]),  64'h4);
      check("ch2_isolated",    64'(locked[2]),         64'h1);
      send_bad(1, 32'h0000_0001);
      check("unrec_count_frozen", 64'(err_count[31:16]), 64'h4);
      check("unrec_no_pulse",     64'(err_pulse),         64'h0);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_unrec",  64'(unrec),  64'h0);
      check("clear_locked", 64'(locked), 64'h0);
      check("clear_counts", err_count,   64'h0);

      // Alternating good/bad on ch3: a 4-bit counter saturates, a 16-bit one keeps counting.
      send_good(3, 9);
      check("sat_locked", 64'(locked_e[3]), 64'h1);
      for (int i = 0; i < 20; i++) begin
         send_good(3, 1);
         send_bad(3, 32'h8000_0000);
         if (i == 14) check("sat_reaches_15", 64'(err_count_e[15:12]), 64'hF);
      end
      check("sat_holds_15",     64'(err_count_e[15:12]), 64'hF);
      check("sat_still_locked", 64'(locked_e[3]),        64'h1);
      check("sat_never_unrec",  64'(unrec_e[3]),         64'h0);
      check("wide_count_20",    64'(err_count[63:48]),   64'd20);

      // Counter mode round-robin on the 3-channel instance, with out-of-range ch=3 words.
      set_mode(3'd0, 0, 0);
      cnt_w[0] = 32'hFFFF_FFFC;
      cnt_w[1] = 32'h0000_1234;
      repeat (8) begin
         send_good(0, 1);
         send_good(1, 1);
         send(2'd3, $urandom);
      end
      check("rr_8_rounds_unlocked", 64'(locked_n), 64'h0);
      send_good(0, 1);
      send_good(1, 1);
      send(2'd3, $urandom);
      check("rr_both_locked", 64'(locked_n),    64'h3);
      check("rr_no_errors",   err_count_n,      64'h0);
      check("rr_no_unrec",    64'(unrec_n),     64'h0);

      // en=0 ignores a garbage word and does not advance history.
      en = 1'b0;
      send(2'd0, 32'hDEAD_BEEF);
      check("en0_no_pulse", 64'(err_pulse_n), 64'h0);
      check("en0_no_count", err_count_n,      64'h0);
      check("en0_hold",     64'(locked_n),    64'h3);
      en = 1'b1;
      send_good(0, 1);
      check("en1_resume_no_pulse", 64'(err_pulse_n), 64'h0);
      check("en1_resume_no_count", err_count_n,      64'h0);

      // clear wins over an errored word in the same cycle.
      clear = 1'b1;
      send(2'd0, 32'h0);
      clear = 1'b0;
      check("clear_err_no_pulse", 64'(err_pulse_n), 64'h0);
      check("clear_err_unlocked", 64'(locked_n),    64'h0);
      check("clear_err_no_count", err_count_n,      64'h0);

      // Mode 5 behaves as counter mode.
      set_mode(3'd5, 0, 0);
      send_good(1, 9);
      check("mode5_counter_locked", 64'(locked_n), 64'h2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
